pmu_acs: RTL and testbench
==========================

PMU_ACS -- requirements
Module: pmu_acs

Interface
REQ-001 The block SHALL be the path-metric / add-compare-select stage of the K=3, rate-1/2 hard-decision Viterbi decoder, consuming the 2-bit received symbol produced by the branch-metric stage.
REQ-002 Parameter: PMW, default 4, path-metric register width in bits.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 Port: valid_in  input  1  bm is valid this cycle and SHALL be processed.
REQ-006 Port: start  input  1  with valid_in, first symbol of a new frame.
REQ-007 Port: bm  input  2  received symbol {cx1,cx0} from the branch-metric stage.
REQ-008 Port: valid_out  output  1  dec, pm_flat and best_state were updated by the previous accepted symbol.
REQ-009 Port: dec  output  4  survivor decision bit per next-state, dec[n] for state n.
REQ-010 Port: pm_flat  output  4*PMW  path metrics, state s at bits [PMW*s+PMW-1 : PMW*s].
REQ-011 Port: best_state  output  2  index of the state with the minimum path metric.

Function
REQ-012 State encoding SHALL be s = {s1,s0}, where s1 is the newest input bit; input u moves state s to next state {u,s1}.
REQ-013 The expected code symbol for input u from state s SHALL be {c1,c0}, where c0 = u^s1^s0 (g=7) and c1 = u^s0 (g=5).
REQ-014 Branch cost SHALL be the Hamming distance popcount(bm ^ {c1,c0}), range 0..2.
REQ-015 For next state n, u = n[1], and the two predecessors SHALL be p = {n[0], p0} with p0 in {0,1}.
REQ-016 Each candidate SHALL be pm[p] + cost, computed at PMW+1 bits with no overflow.
REQ-017 The survivor SHALL be the smaller candidate; on a tie, p0 = 0 wins; dec[n] SHALL equal the winning p0.
REQ-018 Normalization SHALL subtract the minimum of the four survivors from every survivor in the same cycle.
REQ-019 After normalization, any value above 2^PMW-1 SHALL saturate to 2^PMW-1.
REQ-020 best_state SHALL be the lowest-index state whose normalized metric is 0.
REQ-021 Latency SHALL be 1 cycle: a symbol accepted at edge k appears on dec, pm_flat, best_state and valid_out after edge k.
REQ-022 valid_out SHALL be high for exactly one cycle per accepted symbol.
REQ-023 When valid_in is 0, pm_flat, dec and best_state SHALL hold their values, and valid_out SHALL be 0.
REQ-024 When valid_in=1 and start=1, the ACS SHALL use the initial metrics {0,7,7,7} (states 0..3) as pm[p] in place of the stored metrics.
REQ-025 start with valid_in=0 SHALL be ignored.
REQ-026 Back-to-back valid_in SHALL be accepted every cycle without stalls; the block has no backpressure.

Reset
REQ-027 On reset, pm_flat SHALL load the initial metrics: state0=0 and states1..3=7 (16'h7770 for PMW=4).
REQ-028 On reset, dec SHALL be 4'b0000, best_state 2'b00 and valid_out 0.
REQ-029 Reset SHALL take priority over valid_in and start in the same cycle, and any symbol presented in that cycle SHALL be discarded.
REQ-030 Reset asserted mid-frame SHALL return all state to the REQ-027/028 values within one cycle.

Verification
REQ-031 reset, then one symbol bm=00 -> next cycle: valid_out=1, dec=4'b0000, pm_flat=16'h8280, best_state=0.
REQ-032 reset, then one symbol bm=11 -> next cycle: dec=4'b0000, pm_flat=16'h8082, best_state=2.
REQ-033 Stream the encoder output of input bits 1,0,1,1,0,0 from state 0 with no errors -> best_state tracks the encoder state each cycle, and its metric stays 0.
REQ-034 Stream the REQ-033 sequence with one symbol bit flipped -> the minimum metric is 0 after normalization every cycle, and no metric exceeds 15.
REQ-035 valid_in low for 5 cycles mid-stream -> outputs hold, and valid_out is 0 throughout.
REQ-036 Mid-stream symbol bm=00 with start=1 -> result identical to REQ-031 (16'h8280); reset with valid_in=1 -> 16'h7770, valid_out=0.

Source files
------------

// File: rtl/pmu_acs.sv
// pmu_acs - path-metric / add-compare-select stage of the K=3, rate-1/2
// hard-decision Viterbi decoder.
//
// Each accepted symbol bm is scored against the code symbol expected on every
// trellis branch. The cheaper of the two paths into each state survives. The
// four survivors are normalized so the best one is 0, then saturated to the
// register width. Results are registered, so they appear one cycle after the
// symbol is accepted.
//
// Ports
//   clk        rising-edge clock for all state
//   reset      synchronous active-high reset
//   valid_in   bm is valid this cycle and is processed
//   start      with valid_in, first symbol of a frame (ACS uses initial metrics)
//   bm         received symbol {cx1,cx0}
//   valid_out  one-cycle pulse: dec/pm_flat/best_state hold a fresh result
//   dec        survivor decision per next-state, dec[n] = winning p0
//   pm_flat    path metrics, state s at bits [PMW*s +: PMW]
//   best_state lowest-index state whose normalized metric is 0
//
// State s = {s1,s0}, s1 is the newest input bit; input u moves s to {u,s1}.
// Code symbol for input u from state s: c0 = u^s1^s0 (g=7), c1 = u^s0 (g=5).

module pmu_acs #(
   parameter int PMW = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_in,
   input  logic             start,
   input  logic [1:0]       bm,
   output logic             valid_out,
   output logic [3:0]       dec,
   output logic [4*PMW-1:0] pm_flat,
   output logic [1:0]       best_state
);

   localparam logic [PMW-1:0]   PM_INIT  = PMW'(7);
   localparam logic [PMW-1:0]   PM_MAX   = {PMW{1'b1}};
   localparam logic [4*PMW-1:0] PM_RESET = {PM_INIT, PM_INIT, PM_INIT, {PMW{1'b0}}};

   logic [PMW-1:0]   pm_cur   [4];
   logic [PMW:0]     cand0    [4];
   logic [PMW:0]     cand1    [4];
   logic [PMW:0]     surv     [4];
   logic [PMW:0]     min01;
   logic [PMW:0]     min23;
   logic [PMW:0]     min_all;
   logic [PMW:0]     norm     [4];
   logic [3:0]       dec_next;
   logic [4*PMW-1:0] pm_next;
   logic [1:0]       best_next;

   // Hamming distance between the received symbol and the code symbol on
   // the branch leaving state {s1,s0} with input u.
   function automatic logic [1:0] branch_cost(input logic [1:0] sym,
                                              input logic       u,
                                              input logic       s1,
                                              input logic       s0);
      logic [1:0] code;
      logic [1:0] diff;
      code = {u ^ s0, u ^ s1 ^ s0};
      diff = sym ^ code;
      return {1'b0, diff[1]} + {1'b0, diff[0]};
   endfunction

   // Metrics feeding the ACS: a frame start replaces the stored metrics with
   // the known-start-state metrics so a new frame never inherits old history.
   always_comb begin
      for (int s = 0; s < 4; s++) begin
         if (start) begin
            pm_cur[s] = (s == 0) ? {PMW{1'b0}} : PM_INIT;
         end else begin
            pm_cur[s] = pm_flat[PMW*s +: PMW];
         end
      end
   end

   // Add-compare-select. Next state n is reached with u = n[1] from the
   // predecessors {n[0],0} and {n[0],1}; the candidates are one bit wider
   // than the metrics so the add cannot wrap. A tie keeps predecessor p0=0.
   always_comb begin
      dec_next = 4'b0000;
      for (int n = 0; n < 4; n++) begin
         cand0[n] = {1'b0, pm_cur[{n[0], 1'b0}]}
                  + (PMW+1)'(branch_cost(bm, n[1], n[0], 1'b0));
         cand1[n] = {1'b0, pm_cur[{n[0], 1'b1}]}
                  + (PMW+1)'(branch_cost(bm, n[1], n[0], 1'b1));
         if (cand1[n] < cand0[n]) begin
            surv[n]     = cand1[n];
            dec_next[n] = 1'b1;
         end else begin
            surv[n]     = cand0[n];
            dec_next[n] = 1'b0;
         end
      end
   end

   // Normalization: subtract the smallest survivor so the best path sits at
   // 0, then clamp anything that still does not fit in PMW bits.
   always_comb begin
      min01     = (surv[1] < surv[0]) ? surv[1] : surv[0];
      min23     = (surv[3] < surv[2]) ? surv[3] : surv[2];
      min_all   = (min23 < min01) ? min23 : min01;
      pm_next   = '0;
      best_next = 2'd0;
      for (int n = 0; n < 4; n++) begin
         norm[n] = surv[n] - min_all;
         if (norm[n] > {1'b0, PM_MAX}) begin
            pm_next[PMW*n +: PMW] = PM_MAX;
         end else begin
            pm_next[PMW*n +: PMW] = norm[n][PMW-1:0];
         end
      end
      // Scan from the top so the lowest-index zero-metric state wins.
      for (int n = 3; n >= 0; n--) begin
         if (norm[n] == '0) begin
            best_next = 2'(n);
         end
      end
   end

   // Result registers. Reset overrides any symbol presented in the same
   // cycle. Idle cycles hold the last result and drop valid_out.
   always_ff @(posedge clk) begin
      if (reset) begin
         pm_flat    <= PM_RESET;
         dec        <= 4'b0000;
         best_state <= 2'd0;
         valid_out  <= 1'b0;
      end else begin
         valid_out <= valid_in;
         if (valid_in) begin
            pm_flat    <= pm_next;
            dec        <= dec_next;
            best_state <= best_next;
         end
      end
   end

endmodule

// File: tb/tb_pmu_acs.sv
// tb_pmu_acs - self-checking bench for pmu_acs (PMW=4).
//
// Stimulus is driven on the falling edge. Each driven cycle pushes the
// hand-computed expected outputs into a queue. The monitor samples just after
// every rising edge, pops one entry and compares all outputs, so idle/hold
// and reset cycles are checked as well as accepted symbols.

module tb_pmu_acs;

   logic        clk;
   logic        reset;
   logic        valid_in;
   logic        start;
   logic [1:0]  bm;
   logic        valid_out;
   logic [3:0]  dec;
   logic [15:0] pm_flat;
   logic [1:0]  best_state;

   typedef struct {
      int          id;
      logic        v;
      logic [3:0]  dec;
      logic [15:0] pm;
      logic [1:0]  best;
   } exp_t;

   exp_t expQ[$];
   int   testCount = 0;
   int   failCount = 0;
   int   stepId    = 0;

   pmu_acs #(.PMW(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .valid_in   (valid_in),
      .start      (start),
      .bm         (bm),
      .valid_out  (valid_out),
      .dec        (dec),
      .pm_flat    (pm_flat),
      .best_state (best_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs and record what the outputs must be after the
   // next rising edge.
   task automatic applyStimulus(input logic r, input logic vi, input logic st,
                                input logic [1:0] b, input logic ev,
                                input logic [3:0] ed, input logic [15:0] ep,
                                input logic [1:0] eb);
      exp_t e;
      @(negedge clk);
      reset    = r;
      valid_in = vi;
      start    = st;
      bm       = b;
      e.id     = stepId;
      e.v      = ev;
      e.dec    = ed;
      e.pm     = ep;
      e.best   = eb;
      expQ.push_back(e);
      stepId++;
   endtask

   task automatic checkOutput(input exp_t e);
      testCount++;
      if (valid_out !== e.v) begin
         failCount++;
         $display("[TB] FAIL step %0d valid_out: got %b expected %b", e.id, valid_out, e.v);
      end
      testCount++;
      if (dec !== e.dec) begin
         failCount++;
         $display("[TB] FAIL step %0d dec: got %b expected %b", e.id, dec, e.dec);
      end
      testCount++;
      if (pm_flat !== e.pm) begin
         failCount++;
         $display("[TB] FAIL step %0d pm_flat: got %h expected %h", e.id, pm_flat, e.pm);
      end
      testCount++;
      if (best_state !== e.best) begin
         failCount++;
         $display("[TB] FAIL step %0d best_state: got %0d expected %0d", e.id, best_state, e.best);
      end
   endtask

   // Monitor: one expectation per driven cycle; a valid_out with nothing
   // expected is itself an error.
   always @(posedge clk) begin
      #1;
      if (expQ.size() > 0) begin
         checkOutput(expQ.pop_front());
      end else if (valid_out === 1'b1) begin
         testCount++;
         failCount++;
         $display("[TB] FAIL unexpected valid_out: got 1 expected 0");
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset    = 1'b1;
      valid_in = 1'b0;
      start    = 1'b0;
      bm       = 2'b00;
      repeat (3) @(posedge clk);

      $display("[TB] reset state and single-symbol checks");
      applyStimulus(1, 0, 0, 2'b00, 0, 4'b0000, 16'h7770, 2'd0);
      applyStimulus(0, 1, 1, 2'b00, 1, 4'b0000, 16'h8280, 2'd0);
      applyStimulus(1, 0, 0, 2'b00, 0, 4'b0000, 16'h7770, 2'd0);
      applyStimulus(0, 1, 0, 2'b11, 1, 4'b0000, 16'h8082, 2'd2);

      // Error-free encoder output of 1,0,1,1,0,0: 11 01 00 10 10 11,
      // encoder states 2,1,2,3,1,0; five idle cycles after the third symbol.
      $display("[TB] clean stream with idle gap");
      applyStimulus(0, 1, 1, 2'b11, 1, 4'b0000, 16'h8082, 2'd2);
      applyStimulus(0, 1, 0, 2'b01, 1, 4'b0000, 16'h2303, 2'd1);
      applyStimulus(0, 1, 0, 2'b00, 1, 4'b1111, 16'h3032, 2'd2);
      for (int k = 0; k < 5; k++) begin
         applyStimulus(0, 0, (k == 2), 2'b11, 0, 4'b1111, 16'h3032, 2'd2);
      end
      applyStimulus(0, 1, 0, 2'b10, 1, 4'b0000, 16'h0323, 2'd3);
      applyStimulus(0, 1, 0, 2'b10, 1, 4'b1111, 16'h2303, 2'd1);
      applyStimulus(0, 1, 0, 2'b11, 1, 4'b1111, 16'h3230, 2'd0);

      // Same stream, third symbol 00 received as 01.
      $display("[TB] stream with one bit error");
      applyStimulus(0, 1, 1, 2'b11, 1, 4'b0000, 16'h8082, 2'd2);
      applyStimulus(0, 1, 0, 2'b01, 1, 4'b0000, 16'h2303, 2'd1);
      applyStimulus(0, 1, 0, 2'b01, 1, 4'b1101, 16'h1020, 2'd0);
      applyStimulus(0, 1, 0, 2'b10, 1, 4'b0010, 16'h0111, 2'd3);
      applyStimulus(0, 1, 0, 2'b10, 1, 4'b0010, 16'h1202, 2'd1);
      applyStimulus(0, 1, 0, 2'b11, 1, 4'b1011, 16'h2220, 2'd0);

      $display("[TB] mid-stream start and reset priority");
      applyStimulus(0, 1, 1, 2'b00, 1, 4'b0000, 16'h8280, 2'd0);
      applyStimulus(1, 1, 1, 2'b11, 0, 4'b0000, 16'h7770, 2'd0);
      applyStimulus(0, 1, 0, 2'b11, 1, 4'b0000, 16'h8082, 2'd2);

      @(negedge clk);
      reset    = 1'b0;
      valid_in = 1'b0;
      start    = 1'b0;
      bm       = 2'b00;
      repeat (3) @(negedge clk);

      testCount++;
      if (expQ.size() != 0) begin
         failCount++;
         $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
